// File: rtl/pcle_count_reg_if.sv
// rtl/pcle_count_reg_if.sv - control and status bundle for the pcle counter stage
interface pcle_count_reg_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic [WIDTH-1:0] load_data;
  logic             cnt_en;
  logic             hold;
  logic             auto_reload;
  logic             wrap_clr;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] reload_q;
  logic             carry_out;
  logic             wrap_pulse;
  logic             wrap_sticky;

  modport master (
    output load, load_data, cnt_en, hold, auto_reload, wrap_clr,
    input  count, reload_q, carry_out, wrap_pulse, wrap_sticky
  );

  modport slave (
    input  load, load_data, cnt_en, hold, auto_reload, wrap_clr,
    output count, reload_q, carry_out, wrap_pulse, wrap_sticky
  );
endinterface

// File: rtl/pcle_count_reg.sv
// rtl/pcle_count_reg.sv - registered loadable up-counter with auto-reload and wrap flags
module pcle_count_reg #(
  parameter int WIDTH     = 8,
  parameter bit RELOAD_EN = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  pcle_count_reg_if.slave  bus
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             wrap_pulse_q;
  logic             wrap_sticky_q;
  logic             inc;
  logic             tc;
  logic             wrap;
  logic             use_reload;

  assign inc        = bus.cnt_en & ~bus.hold & ~bus.load;
  assign tc         = (count_q == {WIDTH{1'b1}});
  assign wrap       = inc & tc;
  assign use_reload = RELOAD_EN & bus.auto_reload;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q       <= '0;
      reload_q      <= '0;
      wrap_pulse_q  <= 1'b0;
      wrap_sticky_q <= 1'b0;
    end else begin
      if (bus.load) begin
        count_q  <= bus.load_data;
        reload_q <= bus.load_data;
      end else if (wrap) begin
        count_q <= use_reload ? reload_q : '0;
      end else if (inc) begin
        count_q <= count_q + {{(WIDTH-1){1'b0}}, 1'b1};
      end

      wrap_pulse_q <= wrap;
      // A wrap on the same edge as wrap_clr must leave the flag set
      if (wrap) begin
        wrap_sticky_q <= 1'b1;
      end else if (bus.wrap_clr) begin
        wrap_sticky_q <= 1'b0;
      end
    end
  end

  assign bus.count       = count_q;
  assign bus.reload_q    = reload_q;
  assign bus.carry_out   = wrap;
  assign bus.wrap_pulse  = wrap_pulse_q;
  assign bus.wrap_sticky = wrap_sticky_q;

endmodule

// File: tb/tb_pcle_count_reg.sv
// tb/tb_pcle_count_reg.sv - vector table and corner sequences for pcle_count_reg
module tb_pcle_count_reg;

  typedef struct {
    logic       load;
    logic [7:0] load_data;
    logic       cnt_en;
    logic       hold;
    logic       auto_reload;
    logic       wrap_clr;
    logic       exp_carry;
    logic [7:0] exp_count;
    logic [7:0] exp_reload;
    logic       exp_wp;
    logic       exp_ws;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  vec_t vecs[$];

  pcle_count_reg_if #(.WIDTH(8)) bus ();

  pcle_count_reg #(.WIDTH(8), .RELOAD_EN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic ld, input logic [7:0] d, input logic en, input logic hd,
                     input logic ar, input logic wc, input logic ec, input logic [7:0] ecnt,
                     input logic [7:0] erl, input logic ewp, input logic ews);
    vec_t v;
    v.load = ld; v.load_data = d; v.cnt_en = en; v.hold = hd;
    v.auto_reload = ar; v.wrap_clr = wc; v.exp_carry = ec; v.exp_count = ecnt;
    v.exp_reload = erl; v.exp_wp = ewp; v.exp_ws = ews;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic ld, input logic [7:0] d, input logic en, input logic hd,
                       input logic ar, input logic wc);
    bus.load = ld; bus.load_data = d; bus.cnt_en = en; bus.hold = hd;
    bus.auto_reload = ar; bus.wrap_clr = wc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    //  ld  data   en  hd  ar  wc  carry count  reload wp  ws
    add(1, 8'hA5, 1, 0, 0, 0,  0, 8'hA5, 8'hA5, 0, 0);
    add(0, 8'h00, 1, 0, 0, 0,  0, 8'hA6, 8'hA5, 0, 0);
    add(0, 8'h00, 1, 1, 0, 0,  0, 8'hA6, 8'hA5, 0, 0);
    add(1, 8'hFE, 0, 0, 0, 0,  0, 8'hFE, 8'hFE, 0, 0);
    add(0, 8'h00, 1, 1, 0, 0,  0, 8'hFE, 8'hFE, 0, 0);
    add(0, 8'h00, 1, 1, 0, 0,  0, 8'hFE, 8'hFE, 0, 0);
    add(0, 8'h00, 1, 0, 0, 0,  0, 8'hFF, 8'hFE, 0, 0);
    add(1, 8'h10, 1, 0, 0, 0,  0, 8'h10, 8'h10, 0, 0);
    add(1, 8'hFF, 0, 0, 0, 0,  0, 8'hFF, 8'hFF, 0, 0);
    add(0, 8'h00, 1, 1, 0, 0,  0, 8'hFF, 8'hFF, 0, 0);
    add(0, 8'h00, 1, 0, 0, 0,  1, 8'h00, 8'hFF, 1, 1);
    add(0, 8'h00, 0, 0, 0, 0,  0, 8'h00, 8'hFF, 0, 1);
    add(0, 8'h00, 0, 0, 0, 1,  0, 8'h00, 8'hFF, 0, 0);
    add(1, 8'hFC, 0, 0, 0, 0,  0, 8'hFC, 8'hFC, 0, 0);
    add(0, 8'h00, 1, 0, 1, 0,  0, 8'hFD, 8'hFC, 0, 0);
    add(0, 8'h00, 1, 0, 1, 0,  0, 8'hFE, 8'hFC, 0, 0);
    add(0, 8'h00, 1, 0, 1, 0,  0, 8'hFF, 8'hFC, 0, 0);
    add(0, 8'h00, 1, 0, 1, 0,  1, 8'hFC, 8'hFC, 1, 1);
    add(0, 8'h00, 1, 0, 1, 0,  0, 8'hFD, 8'hFC, 0, 1);
    add(1, 8'hFF, 0, 0, 0, 0,  0, 8'hFF, 8'hFF, 0, 1);
    add(0, 8'h00, 1, 0, 1, 1,  1, 8'hFF, 8'hFF, 1, 1);
    add(0, 8'h00, 1, 0, 1, 0,  1, 8'hFF, 8'hFF, 1, 1);
    add(0, 8'h00, 0, 0, 1, 1,  0, 8'hFF, 8'hFF, 0, 0);
    add(1, 8'h10, 1, 0, 0, 0,  0, 8'h10, 8'h10, 0, 0);
    add(0, 8'h00, 1, 0, 0, 0,  0, 8'h11, 8'h10, 0, 0);

    #1;
    chk("reset_count", bus.count, 8'h00);
    chk("reset_reload", bus.reload_q, 8'h00);
    chk("reset_wrap_pulse", bus.wrap_pulse, 1'b0);
    chk("reset_wrap_sticky", bus.wrap_sticky, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].load, vecs[i].load_data, vecs[i].cnt_en, vecs[i].hold,
            vecs[i].auto_reload, vecs[i].wrap_clr);
      #1;
      chk($sformatf("v%0d_carry", i), bus.carry_out, vecs[i].exp_carry);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_count", i), bus.count, vecs[i].exp_count);
      chk($sformatf("v%0d_reload", i), bus.reload_q, vecs[i].exp_reload);
      chk($sformatf("v%0d_wrap_pulse", i), bus.wrap_pulse, vecs[i].exp_wp);
      chk($sformatf("v%0d_wrap_sticky", i), bus.wrap_sticky, vecs[i].exp_ws);
    end

    // Free-run from reset through a natural wrap
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("fr_start", bus.count, 8'h00);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (255) @(posedge clk);
    @(negedge clk);
    chk("fr_ff", bus.count, 8'hFF);
    chk("fr_carry_ff", bus.carry_out, 1'b1);
    chk("fr_sticky_pre", bus.wrap_sticky, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("fr_wrap_count", bus.count, 8'h00);
    chk("fr_wrap_pulse", bus.wrap_pulse, 1'b1);
    chk("fr_wrap_sticky", bus.wrap_sticky, 1'b1);
    chk("fr_carry_00", bus.carry_out, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("fr_after_count", bus.count, 8'h01);
    chk("fr_after_pulse", bus.wrap_pulse, 1'b0);
    chk("fr_after_sticky", bus.wrap_sticky, 1'b1);

    // Asynchronous reset between edges at 0x37
    repeat (8'h36) @(posedge clk);
    @(negedge clk);
    chk("ar_pre_count", bus.count, 8'h37);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_count", bus.count, 8'h00);
    chk("ar_sticky", bus.wrap_sticky, 1'b0);
    chk("ar_reload", bus.reload_q, 8'h00);
    @(negedge clk);
    chk("ar_held", bus.count, 8'h00);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ar_resume", bus.count, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pcle_count_reg.md
Name: pcle_count_reg

Overview:
- State-holding stage wrapped around the team's combinational "pcle" counter next-state logic: a registered WIDTH-bit loadable up-counter.
- Inputs: parallel load, count enable and count inhibit controls; the stage holds the counter state and feeds it back for the next increment.
- Adds the sequential functions the combinational slice lacks: registered count, auto-reload from a latched reload value, registered wrap pulse, sticky wrap flag, and a combinational cascade carry for chaining stages.

Parameters:
- WIDTH, 8, counter and load-data width in bits (legal range 2..32).
- RELOAD_EN, 1, 1 = auto-reload logic present; 0 = auto_reload input ignored, counter always wraps to 0.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- load  input  1  parallel load strobe; highest priority.
- load_data  input  WIDTH  value written to count (and reload_q) when load=1.
- cnt_en  input  1  count enable.
- hold  input  1  count inhibit; when 1, blocks counting but not load.
- auto_reload  input  1  1 = on wrap, reload from reload_q instead of 0.
- wrap_clr  input  1  clears wrap_sticky.
- count  output  WIDTH  registered counter value.
- reload_q  output  WIDTH  registered copy of last loaded value.
- carry_out  output  1  combinational terminal-count carry for cascading.
- wrap_pulse  output  1  registered one-cycle wrap indication.
- wrap_sticky  output  1  registered sticky wrap flag.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately without a clock edge): count=0, reload_q=0, wrap_pulse=0, wrap_sticky=0. Reset asserted mid-count aborts the operation; after release the first edge behaves as from power-up.
- Define inc = cnt_en & ~hold & ~load.
- Define tc = (count == all ones).
- Next-state priority at each rising edge:
  1. load=1: count <= load_data; reload_q <= load_data. Counting is ignored that cycle, even if tc.
  2. Else if inc=1 and tc=0: count <= count+1, computed modulo 2^WIDTH with no carry stored.
  3. Else if inc=1 and tc=1 (wrap): count <= reload_q when RELOAD_EN=1 and auto_reload=1, else count <= 0.
  4. Else: count holds.
- reload_q changes only on load.
- carry_out = inc & tc. Purely combinational, zero latency; it is the carry to a following stage's cnt_en. Never asserted while load=1 or hold=1.
- wrap_pulse <= (inc & tc). High exactly for the cycle after the wrap edge; deasserts next cycle unless another wrap occurs.
- Back-to-back wraps: possible only when reload_q is all ones with auto_reload=1. wrap_pulse then stays high continuously.
- wrap_sticky <= 1 on a wrap edge. Else 0 if wrap_clr=1. Else holds. A simultaneous wrap and wrap_clr leaves sticky = 1 (set wins).
- Load of all ones: count=all ones next cycle; tc true; the next inc edge wraps.
- Latency:
  - load to count visible: 1 cycle.
  - enable edge to increment visible: 1 cycle.
  - wrap to wrap_pulse: 1 cycle.
  - carry_out: same cycle.
- No X propagation: every register has a defined reset value; outputs are defined whenever rst_n=1 after the first edge.

Test Plan:
- Reset then free-run (WIDTH=8, cnt_en=1, hold=0, auto_reload=0): count is 0,1,2,... and reaches 0xFF after 255 edges. carry_out=1 during the 0xFF cycle; next edge count=0x00. wrap_pulse=1 for one cycle; wrap_sticky=1 afterwards.
- Load priority: count=0x10, load=1, load_data=0xA5, cnt_en=1 → count=0xA5 (not 0x11); reload_q=0xA5; carry_out=0 during the load cycle even at count=0xFF.
- Hold: count=0xFE, cnt_en=1, hold=1 for 5 edges → count stays 0xFE, carry_out=0. Release hold → 0xFF, then wrap to 0x00.
- Auto-reload: load 0xFC, auto_reload=1, count enabled → sequence FC,FD,FE,FF,FC,FD..., with wrap_pulse high in the cycle after each FF→FC transition. With reload_q=0xFF, wrap_pulse stays continuously high.
- Sticky clear race: wrap_clr=1 on the same edge as a wrap → wrap_sticky=1. wrap_clr=1 on the following edge with no wrap → wrap_sticky=0.
- Asynchronous reset mid-count: assert rst_n=0 between edges at count=0x37 → count=0 and wrap_sticky=0 immediately, before the next clock edge. Deassert → counting resumes from 0x00.
